posit_sqrt_unit: RTL and testbench
==================================

Name: posit_sqrt_unit

Overview:
- Pipelined square root for standard posit<N,ES> words; default posit32, es=2.
- Decodes the input into sign, regime k, exponent and fraction, takes sqrt of the magnitude, and re-encodes a posit.
- Sits in the posit arithmetic datapath beside add/mul units and uses the shared posit decode conventions.

Parameters:
- N, 32, posit word width.
- ES, 2, exponent field width; useed = 2^(2^ES).
- RS, $clog2(N), width-1 of the signed regime value k, which is RS+1 bits signed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid this cycle.
- in_posit  in  N  input posit bit pattern.
- out_valid  out  1  out_posit holds a result this cycle.
- out_posit  out  N  sqrt result posit.
- out_nar  out  1  result is NaR.
- out_zero  out  1  result is zero.

Behaviour:
- Reset: out_valid=0, out_posit=0, out_nar=0, out_zero=0. Pipeline valid bits are cleared. An in-flight operation during reset is discarded.
- Fixed latency of 2 cycles:
  - Stage 1 registers the decode.
  - Stage 2 registers sqrt plus encode.
  - in_valid at edge t gives out_valid=1 after edge t+2.
- Fully pipelined: accepts a new word every cycle, with no back-pressure. Outputs hold their last value when out_valid=0.
- Decode (two's-complement magnitude for negatives):
  - zero = (in==0).
  - NaR = (in==1 followed by N-1 zeros).
  - Regime run of m identical bits after the sign: k = m-1 if the run is 1s, k = -m if the run is 0s.
  - Then ES exponent bits; missing bits read as 0.
  - The remaining bits are the fraction with a hidden 1.
- Scale s = k*2^ES + e, as a signed value.
- Special cases:
  - NaR in -> out_posit = 1 followed by N-1 zeros, out_nar=1.
  - Negative nonzero input -> NaR, out_nar=1.
  - Zero in -> out_posit=0, out_zero=1.
- Normal path:
  - If s is even: root = sqrt(1.f), new scale = s/2.
  - If s is odd: root = sqrt(2*1.f), new scale = (s-1)/2, i.e. arithmetic shift right.
  - root is in [1,2). Compute it with a restoring digit-by-digit integer sqrt over a fraction-width + 2 guard bits operand; keep the nonzero remainder as sticky.
- Encode:
  - k' = newscale >>> ES; e' = newscale mod 2^ES.
  - Build regime, exponent and fraction, truncated to N-1 bits after the sign bit 0.
  - The result is always positive.
  - Magnitude always lies in [minpos, maxpos]; no saturation logic is needed beyond clamping to maxpos/minpos defensively.
- out_nar and out_zero are mutually exclusive. Both are 0 for a normal result.

Optional Feature:
- Macro POSIT_SQRT_ROUND_EN.
- Defined: round-to-nearest-even at the final bit position, using the guard bit and sticky (lower bits plus sqrt remainder). A carry into regime/exponent is propagated by integer increment of the N-1 bit magnitude, clamped to maxpos.
- Undefined: truncation (round toward zero); no rounding logic is present.

Decomposition:
- Package posit_pkg:
  - N/ES defaults.
  - NaR and zero constants.
  - Decoded-posit struct typedef: sign, nar, zero, k, exp, frac.
  - Encode helper function: k, exp, frac, guard, sticky to posit.
- One sub-module: posit_decode, the combinational decode used in stage 1.
- sqrt core and encode live in posit_sqrt_unit.

Test Plan:
- 0x40000000 (1.0) -> 0x40000000. 0x50000000 (4.0) -> 0x48000000 (2.0). 0x60000000 (16.0) -> 0x50000000.
- 0x48000000 (2.0, odd scale) -> 0x43504F33 (sqrt 2, same with and without rounding).
- 0x00000000 -> 0x00000000, out_zero=1. 0x80000000 -> 0x80000000, out_nar=1. 0xC0000000 (-1.0) -> 0x80000000, out_nar=1.
- 0x00000001 (minpos, 2^-120) -> 0x00008000 (2^-60). 0x7FFFFFFF (maxpos, 2^120) -> 0x7FFF8000 (2^60).
- Back-to-back in_valid for 8 cycles with mixed values -> 8 consecutive out_valid cycles, in order, each exactly 2 cycles after its input.
- Assert rst while valid words are in flight -> next cycle out_valid=0, all outputs 0, in-flight results never appear.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit<N,ES> constants, the decoded-word record and the encode helper.
// POSIT_SQRT_ROUND_EN selects round-to-nearest-even in posit_encode; otherwise the result is truncated.
package posit_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int POSIT_RS = $clog2(POSIT_N);
  localparam int POSIT_RW = POSIT_RS + 1;
  localparam int POSIT_KW = POSIT_RS + 2;
  localparam int POSIT_FW = POSIT_N - 3 - POSIT_ES;
  localparam int POSIT_VW = 2 * POSIT_N;

  localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] POSIT_ZERO = {POSIT_N{1'b0}};

  typedef struct packed {
    logic                       sign;
    logic                       nar;
    logic                       zero;
    logic signed [POSIT_RS:0]   k;
    logic [POSIT_ES-1:0]        exp;
    logic [POSIT_FW-1:0]        frac;
  } posit_dec_t;

  // frac carries FW+1 bits; guard is the next bit of the stream, sticky ORs everything below it.
  function automatic logic [POSIT_N-1:0] posit_encode(
    input logic signed [POSIT_RS:0] k,
    input logic [POSIT_ES-1:0]      exp,
    input logic [POSIT_FW:0]        frac,
    input logic                     guard,
    input logic                     sticky
  );
    logic [POSIT_VW-1:0] v;
    logic [POSIT_VW-1:0] tail;
    logic [POSIT_KW-1:0] kx;
    logic [POSIT_KW-1:0] len;
    logic [POSIT_N-2:0]  mag;
    logic                g;
    logic                st;
    kx   = {k[POSIT_RS], k};
    tail = {exp, frac, guard, {(POSIT_VW-POSIT_N+1){1'b0}}};
    if (!k[POSIT_RS]) begin
      len = kx + POSIT_KW'(2);
      v   = ~({POSIT_VW{1'b1}} >> (kx + POSIT_KW'(1)));
    end else begin
      len = POSIT_KW'(1) - kx;
      v   = {1'b1, {(POSIT_VW-1){1'b0}}} >> (POSIT_KW'(0) - kx);
    end
    v   = v | (tail >> len);
    mag = v[POSIT_VW-1 -: POSIT_N-1];
    g   = v[POSIT_VW-POSIT_N];
    st  = (|v[POSIT_VW-POSIT_N-1:0]) | sticky;
`ifdef POSIT_SQRT_ROUND_EN
    if (g && (st || mag[0]) && !(&mag)) begin
      mag = mag + (POSIT_N-1)'(1);
    end else begin
      mag = mag;
    end
`endif
    // A nonzero value never encodes as zero: fall back to minpos.
    if (mag == '0 && (g || st)) begin
      mag = (POSIT_N-1)'(1);
    end else begin
      mag = mag;
    end
    return {1'b0, mag};
  endfunction

endpackage

// File: rtl/posit_decode.sv
// Combinational posit decode into sign, special flags, regime k, exponent and left-aligned fraction.
module posit_decode
  import posit_pkg::*;
(
  input  logic [POSIT_N-1:0] in_posit,
  output posit_dec_t         dec
);

  logic [POSIT_N-2:0]          body;
  logic [POSIT_ES+POSIT_FW-1:0] rest;
  logic [POSIT_RS:0]           run;
  logic                        done;

  // Regime run length, then the exponent and fraction that follow the terminator.
  always_comb begin
    body = in_posit[POSIT_N-1] ? (~in_posit[POSIT_N-2:0] + (POSIT_N-1)'(1)) : in_posit[POSIT_N-2:0];
    run  = '0;
    done = 1'b0;
    for (int i = POSIT_N - 2; i >= 0; i--) begin
      if (!done && body[i] == body[POSIT_N-2]) begin
        run = run + POSIT_RW'(1);
      end else begin
        done = 1'b1;
      end
    end
    // run >= 1 and the top two bits are always regime, so shifting the low bits by run-1 aligns the tail.
    rest     = body[POSIT_ES+POSIT_FW-1:0] << (run - POSIT_RW'(1));
    dec.sign = in_posit[POSIT_N-1];
    dec.nar  = (in_posit == POSIT_NAR);
    dec.zero = (in_posit == POSIT_ZERO);
    dec.k    = body[POSIT_N-2] ? $signed(run - POSIT_RW'(1)) : $signed(POSIT_RW'(0) - run);
    dec.exp  = rest[POSIT_ES+POSIT_FW-1 -: POSIT_ES];
    dec.frac = rest[POSIT_FW-1:0];
  end

endmodule

// File: rtl/posit_sqrt_unit.sv
// Two-stage pipelined posit square root: stage 1 registers the decode, stage 2 the root and re-encode.
// Define POSIT_SQRT_ROUND_EN for round-to-nearest-even; the default build truncates.
module posit_sqrt_unit
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_posit,
  output logic         out_valid,
  output logic [N-1:0] out_posit,
  output logic         out_nar,
  output logic         out_zero
);

  localparam int RTW = POSIT_FW + 3;
  localparam int QW  = 2 * RTW;
  localparam int SW  = RS + ES + 1;

  posit_dec_t dec;
  posit_dec_t s1_dec;
  logic       s1_valid;

  posit_decode u_decode (
    .in_posit (in_posit),
    .dec      (dec)
  );

  // Stage 1: capture the decoded word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dec   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_dec   <= dec;
    end
  end

  logic signed [SW-1:0] scale;
  logic signed [SW-1:0] new_scale;
  logic signed [RS:0]   k_new;
  logic [ES-1:0]        exp_new;
  logic [QW-1:0]        radicand;
  logic [RTW-1:0]       root;
  logic [RTW+1:0]       rem;
  logic [RTW+1:0]       trial;
  logic [N-1:0]         result;
  logic                 result_nar;
  logic                 result_zero;

  // Restoring digit-by-digit root of 1.f (doubled for odd scale), then re-encode.
  always_comb begin
    scale     = {s1_dec.k, s1_dec.exp};
    new_scale = scale >>> 1'b1;
    k_new     = new_scale[SW-1:ES];
    exp_new   = new_scale[ES-1:0];
    radicand  = scale[0] ? {1'b1, s1_dec.frac, {(QW-POSIT_FW-1){1'b0}}}
                         : {1'b0, 1'b1, s1_dec.frac, {(QW-POSIT_FW-2){1'b0}}};
    rem  = '0;
    root = '0;
    for (int i = RTW - 1; i >= 0; i--) begin
      rem   = {rem[RTW-1:0], radicand[2*i+1 -: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[RTW-2:0], 1'b1};
      end else begin
        root = {root[RTW-2:0], 1'b0};
      end
    end
    result_nar  = s1_dec.nar | s1_dec.sign;
    result_zero = s1_dec.zero & ~s1_dec.sign;
    if (result_nar) begin
      result = POSIT_NAR;
    end else if (result_zero) begin
      result = POSIT_ZERO;
    end else begin
      result = posit_encode(k_new, exp_new, root[RTW-2:1], root[0], |rem);
    end
  end

  // Stage 2: registered outputs, held while no result is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_nar   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_posit <= result;
        out_nar   <= result_nar;
        out_zero  <= result_zero;
      end
    end
  end

endmodule

// File: tb/tb_posit_sqrt_unit.sv
// Scoreboard bench for posit_sqrt_unit: directed values, random words against a bit-string reference model,
// back-to-back latency checks and reset with words in flight.
module tb_posit_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_posit;
  logic        out_valid;
  logic [31:0] out_posit;
  logic        out_nar;
  logic        out_zero;

  posit_sqrt_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_posit (out_posit),
    .out_nar   (out_nar),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] posit;
    bit          nar;
    bit          zero;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          hold_en  = 0;
  logic [31:0] last_out = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: walk the word as a bit string, take an exact integer root, rebuild the bit string.
  function automatic exp_t model(input logic [31:0] p);
    exp_t        r;
    int          i, m, k, e, s, fb, odd, ns, kr, er;
    bit          first, g, st, exact;
    longint      frac, rad, rt;
    bit          bits[$];
    logic [30:0] mag;
    r.nar = 0; r.zero = 0; r.due = 0; r.posit = 32'h0;
    if (p == 32'h0) begin r.zero = 1; return r; end
    if (p[31]) begin r.nar = 1; r.posit = 32'h8000_0000; return r; end
    first = p[30]; m = 0; i = 30;
    while (i >= 0 && p[i] == first) begin m++; i--; end
    k = first ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = 2 * e + ((i >= 0) ? int'(p[i]) : 0);
      i--;
    end
    fb = (i >= 0) ? i + 1 : 0;
    frac = 0;
    for (int j = fb - 1; j >= 0; j--) frac = 2 * frac + longint'(p[j]);
    s   = 4 * k + e;
    odd = (s % 2 != 0) ? 1 : 0;
    ns  = (s - odd) / 2;
    rad = ((longint'(1) << fb) + frac) << (60 - fb + odd);
    rt  = longint'($sqrt(real'(rad)));
    while (rt * rt > rad) rt--;
    while ((rt + 1) * (rt + 1) <= rad) rt++;
    exact = (rt * rt == rad);
    er = ((ns % 4) + 4) % 4;
    kr = (ns - er) / 4;
    if (kr >= 0) begin
      for (int j = 0; j <= kr; j++) bits.push_back(1'b1);
      bits.push_back(1'b0);
    end else begin
      for (int j = 0; j < -kr; j++) bits.push_back(1'b0);
      bits.push_back(1'b1);
    end
    bits.push_back(er[1]);
    bits.push_back(er[0]);
    for (int j = 29; j >= 0; j--) bits.push_back(rt[j]);
    mag = 31'h0;
    for (int j = 0; j < 31; j++) mag = {mag[29:0], (j < bits.size()) ? bits[j] : 1'b0};
    g  = (bits.size() > 31) ? bits[31] : 1'b0;
    st = !exact;
    for (int j = 32; j < bits.size(); j++) st = st | bits[j];
`ifdef POSIT_SQRT_ROUND_EN
    if (g && (st || mag[0]) && mag != 31'h7FFF_FFFF) mag = mag + 31'd1;
`endif
    r.posit = {1'b0, mag};
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] p, input bit nar, input bit zero);
    exp_t r;
    r.posit = p; r.nar = nar; r.zero = zero; r.due = 0;
    return r;
  endfunction

  task automatic send(input logic [31:0] p, input exp_t e);
    @(negedge clk);
    in_valid = 1'b1;
    in_posit = p;
    e.due = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_posit = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid with posit %h, expected no result", out_posit);
      end else begin
        e = exp_q.pop_front();
        check("posit", out_posit, e.posit);
        check("nar", {31'b0, out_nar}, {31'b0, e.nar});
        check("zero", {31'b0, out_zero}, {31'b0, e.zero});
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
      last_out = out_posit;
    end else begin
      if (hold_en) check("hold", out_posit, last_out);
      if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_out: got no out_valid at cycle %0d, expected %h", e.due, e.posit);
      end
    end
  end

  initial begin
    logic [31:0] p;
    rst = 1'b1; in_valid = 1'b0; in_posit = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_posit", out_posit, 32'h0);
    check("rst_out_nar", {31'b0, out_nar}, 32'h0);
    check("rst_out_zero", {31'b0, out_zero}, 32'h0);
    rst = 1'b0;
    last_out = 32'h0;
    hold_en = 1;

    // Back-to-back directed words with known roots.
    send(32'h4000_0000, mk(32'h4000_0000, 0, 0));
    send(32'h5000_0000, mk(32'h4800_0000, 0, 0));
    send(32'h6000_0000, mk(32'h5000_0000, 0, 0));
    send(32'h4800_0000, mk(32'h4350_4F33, 0, 0));
    send(32'h0000_0000, mk(32'h0000_0000, 0, 1));
    send(32'h8000_0000, mk(32'h8000_0000, 1, 0));
    send(32'hC000_0000, mk(32'h8000_0000, 1, 0));
    send(32'h0000_0001, mk(32'h0000_8000, 0, 0));
    send(32'h7FFF_FFFF, mk(32'h7FFF_8000, 0, 0));
    idle();
    drain();

    // Random words, with shifts to reach extreme regimes and occasional idle gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        idle();
      end else begin
        p = $urandom;
        if ($urandom_range(1) == 0) p = p >> $urandom_range(31);
        if ($urandom_range(3) != 0) p[31] = 1'b0;
        send(p, model(p));
      end
    end
    idle();
    drain();

    // Reset while two words are in flight: neither may ever appear.
    send(32'h5000_0000, mk(32'h4800_0000, 0, 0));
    idle();
    drain();
    @(negedge clk);
    in_valid = 1'b1; in_posit = 32'h6000_0000;
    @(negedge clk);
    in_posit = 32'h4800_0000; rst = 1'b1; hold_en = 0;
    @(negedge clk);
    in_valid = 1'b0;
    check("flight_out_valid", {31'b0, out_valid}, 32'h0);
    check("flight_out_posit", out_posit, 32'h0);
    check("flight_out_nar", {31'b0, out_nar}, 32'h0);
    check("flight_out_zero", {31'b0, out_zero}, 32'h0);
    rst = 1'b0;
    last_out = 32'h0;
    hold_en = 1;
    repeat (6) @(negedge clk);
    send(32'h6000_0000, mk(32'h5000_0000, 0, 0));
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
